// File: rtl/audio_tone_pkg.sv
// Shared types and helpers for the audio test-tone source.
// Waveform encoding and divider sizing are used by the top level and the strobe divider.
package audio_tone_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW      = 2'd0,
      WAVE_SQUARE   = 2'd1,
      WAVE_TRIANGLE = 2'd2,
      WAVE_SILENCE  = 2'd3
   } wave_mode_t;

   // The accumulator must hold acc+AUDIO_RATE before the wrap subtraction.
   function automatic int acc_width(input longint clk_rate, input longint audio_rate);
      return $clog2(clk_rate + audio_rate);
   endfunction

endpackage

// File: rtl/audio_tone_source_if.sv
// Per-channel tone controls in, audio strobe and sample words out.
// master drives the controls (HDMI glue or bench); slave is the tone source.
interface audio_tone_source_if
   import audio_tone_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int W        = 16,
   parameter int P        = 24
);
   logic [P-1:0]        phase_inc   [CHANNELS];
   wave_mode_t          wave_mode   [CHANNELS];
   logic [3:0]          atten       [CHANNELS];
   logic                audio_tick;
   logic signed [W-1:0] sample_word [CHANNELS];
   logic                sample_valid;

   modport master (
      output phase_inc, wave_mode, atten,
      input  audio_tick, sample_word, sample_valid
   );

   modport slave (
      input  phase_inc, wave_mode, atten,
      output audio_tick, sample_word, sample_valid
   );
endinterface

// File: rtl/audio_rate_strobe.sv
// Fractional (Bresenham) divider: emits exactly AUDIO_RATE one-cycle ticks
// every CLK_RATE cycles, with spacing floor or ceil of CLK_RATE/AUDIO_RATE.
module audio_rate_strobe
   import audio_tone_pkg::*;
#(
   parameter int CLK_RATE   = 74250000,
   parameter int AUDIO_RATE = 48000
) (
   input  logic clk_pixel,
   input  logic reset,
   output logic audio_tick
);
   localparam int ACC_W = acc_width(CLK_RATE, AUDIO_RATE);
   localparam logic [ACC_W-1:0] CLK_C   = ACC_W'(CLK_RATE);
   localparam logic [ACC_W-1:0] AUDIO_C = ACC_W'(AUDIO_RATE);

   if (!(AUDIO_RATE > 0 && AUDIO_RATE < CLK_RATE)) begin : g_bad_rate
      $error("audio_rate_strobe: need 0 < AUDIO_RATE < CLK_RATE");
   end

   logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
   logic             tick_q, tick_d;

   always_comb begin
      acc_sum = acc_q + AUDIO_C;
      acc_d   = acc_sum;
      tick_d  = 1'b0;
      if (acc_sum >= CLK_C) begin
         acc_d  = acc_sum - CLK_C;
         tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         acc_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         tick_q <= tick_d;
      end
   end

   assign audio_tick = tick_q;
endmodule

// File: rtl/audio_tone_source.sv
// Multi-channel HDMI test-tone generator in the pixel clock domain: strobe,
// then phase update (stage 1), then shaped and attenuated sample (stage 2).
module audio_tone_source
   import audio_tone_pkg::*;
#(
   parameter int CLK_RATE        = 74250000,
   parameter int AUDIO_RATE      = 48000,
   parameter int AUDIO_BIT_WIDTH = 16,
   parameter int CHANNELS        = 2,
   parameter int PHASE_WIDTH     = 24
) (
   input  logic                clk_pixel,
   input  logic                reset,
   audio_tone_source_if.slave  tone
);
   localparam int W = AUDIO_BIT_WIDTH;
   localparam int P = PHASE_WIDTH;
   localparam logic signed [W-1:0] SQ_MAX = {1'b0, {(W-1){1'b1}}};

   if (P < W + 1) begin : g_bad_width
      $error("audio_tone_source: PHASE_WIDTH must be at least AUDIO_BIT_WIDTH+1");
   end

   function automatic logic signed [W-1:0] shape(input logic [P-1:0] ph, input wave_mode_t m);
      logic [W-1:0] u, v, t;
      u = ph[P-1 -: W];
      v = ph[P-2 -: W];
      t = ph[P-1] ? ~v : v;
      case (m)
         WAVE_SAW:      return $signed({~u[W-1], u[W-2:0]});
         WAVE_SQUARE:   return ph[P-1] ? -SQ_MAX : SQ_MAX;
         WAVE_TRIANGLE: return $signed({~t[W-1], t[W-2:0]});
         default:       return '0;
      endcase
   endfunction

   // Shifts of W or more collapse to the sign: 0 or -1.
   function automatic logic signed [W-1:0] attenuate(input logic signed [W-1:0] x,
                                                    input logic [3:0] a);
      if (int'(a) >= W) return x >>> (W - 1);
      return x >>> a;
   endfunction

   logic tick;
   logic vld_p1_q, vld_p2_q;

   audio_rate_strobe #(
      .CLK_RATE   (CLK_RATE),
      .AUDIO_RATE (AUDIO_RATE)
   ) u_strobe (
      .clk_pixel  (clk_pixel),
      .reset      (reset),
      .audio_tick (tick)
   );

   // Stage boundaries: tick -> phase/shadow update (p1) -> sample register (p2).
   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= tick;
         vld_p2_q <= vld_p1_q;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [P-1:0]        phase_q, phase_d;
      wave_mode_t          mode_q;
      logic [3:0]          atten_q;
      logic signed [W-1:0] sample_q;

      assign phase_d = phase_q + tone.phase_inc[c];

      always_ff @(posedge clk_pixel) begin
         if (reset) begin
            phase_q  <= '0;
            mode_q   <= WAVE_SAW;
            atten_q  <= '0;
            sample_q <= '0;
         end else begin
            if (tick) begin
               phase_q <= phase_d;
               mode_q  <= tone.wave_mode[c];
               atten_q <= tone.atten[c];
            end
            if (vld_p1_q) begin
               sample_q <= attenuate(shape(phase_q, mode_q), atten_q);
            end
         end
      end

      assign tone.sample_word[c] = sample_q;
   end

   assign tone.audio_tick   = tick;
   assign tone.sample_valid = vld_p2_q;
endmodule

// File: tb/tb_audio_tone_source.sv
// Randomized and directed bench for audio_tone_source at CLK_RATE=10, AUDIO_RATE=3,
// checked every cycle against an arithmetic reference model.
module tb_audio_tone_source;
   import audio_tone_pkg::*;

   localparam int CR = 10;
   localparam int AR = 3;
   localparam int W  = 16;
   localparam int P  = 24;
   localparam int CH = 2;

   logic clk_pixel = 1'b0;
   logic reset     = 1'b1;

   audio_tone_source_if #(.CHANNELS(CH), .W(W), .P(P)) tone_if ();

   audio_tone_source #(
      .CLK_RATE        (CR),
      .AUDIO_RATE      (AR),
      .AUDIO_BIT_WIDTH (W),
      .CHANNELS        (CH),
      .PHASE_WIDTH     (P)
   ) dut (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .tone      (tone_if)
   );

   always #5 clk_pixel = ~clk_pixel;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: edges since release, tick/stage flags, per-channel state.
   longint n_m;
   bit     tick_m, s1_m, valid_m;
   longint phase_m  [CH];
   int     mode_m   [CH];
   int     atten_m  [CH];
   longint sample_m [CH];
   longint q0[$], q1[$];

   function automatic longint ref_wave(input longint ph, input int mode, input int at);
      longint half, k, v, dv;
      half = longint'(1) << (W - 1);
      case (mode)
         0: v = (ph >> (P - W)) - half;
         1: v = (ph < (longint'(1) << (P - 1))) ? half - 1 : -(half - 1);
         2: begin
            k = ph >> (P - 1 - W);
            v = (k < 2 * half) ? k - half : (4 * half - 1 - k) - half;
         end
         default: v = 0;
      endcase
      if (at >= W) at = W - 1;
      dv = longint'(1) << at;
      return (v >= 0) ? v / dv : -((-v + dv - 1) / dv);
   endfunction

   function automatic bit tick_at(input longint n);
      return ((n * AR) / CR) != (((n - 1) * AR) / CR);
   endfunction

   task automatic model_edge();
      if (reset) begin
         n_m = 0; tick_m = 0; s1_m = 0; valid_m = 0;
         for (int c = 0; c < CH; c++) begin
            phase_m[c] = 0; mode_m[c] = 0; atten_m[c] = 0; sample_m[c] = 0;
         end
      end else begin
         valid_m = s1_m;
         if (s1_m)
            for (int c = 0; c < CH; c++)
               sample_m[c] = ref_wave(phase_m[c], mode_m[c], atten_m[c]);
         s1_m = tick_m;
         if (tick_m)
            for (int c = 0; c < CH; c++) begin
               phase_m[c] = (phase_m[c] + longint'(tone_if.phase_inc[c])) % (longint'(1) << P);
               mode_m[c]  = int'(tone_if.wave_mode[c]);
               atten_m[c] = int'(tone_if.atten[c]);
            end
         n_m++;
         tick_m = tick_at(n_m);
      end
   endtask

   task automatic step();
      @(posedge clk_pixel);
      model_edge();
      #1;
      chk("audio_tick", longint'(tone_if.audio_tick), longint'(tick_m));
      chk("sample_valid", longint'(tone_if.sample_valid), longint'(valid_m));
      for (int c = 0; c < CH; c++)
         chk($sformatf("sample_word[%0d]", c), longint'(tone_if.sample_word[c]), sample_m[c]);
      if (tone_if.sample_valid === 1'b1) begin
         q0.push_back(longint'(tone_if.sample_word[0]));
         q1.push_back(longint'(tone_if.sample_word[1]));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   task automatic set_ch(input int c, input logic [P-1:0] inc, input int mode, input int at);
      tone_if.phase_inc[c] = inc;
      tone_if.wave_mode[c] = wave_mode_t'(mode[1:0]);
      tone_if.atten[c]     = at[3:0];
   endtask

   task automatic randomize_inputs(input int prob);
      for (int c = 0; c < CH; c++)
         if ($urandom_range(0, 99) < prob)
            set_ch(c, P'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
   endtask

   initial begin
      int cnt;
      int k;
      for (int c = 0; c < CH; c++) set_ch(c, '0, 0, 0);

      // Square and triangle at quarter-cycle steps.
      do_reset();
      set_ch(0, 24'h400000, 1, 0);
      set_ch(1, 24'h400000, 2, 0);
      for (int i = 0; i < 16; i++) step();
      chk("sq_count", q0.size(), 4);
      if (q0.size() >= 4) begin
         chk("sq0", q0[0], 32767);  chk("sq1", q0[1], -32767);
         chk("sq2", q0[2], -32767); chk("sq3", q0[3], 32767);
         chk("tri0", q1[0], 0);     chk("tri1", q1[1], 32767);
         chk("tri2", q1[2], -1);    chk("tri3", q1[3], -32768);
      end

      // Attenuation by 9 and by the full width.
      do_reset();
      set_ch(0, 24'h400000, 1, 9);
      set_ch(1, 24'h400000, 1, 15);
      for (int i = 0; i < 10; i++) step();
      chk("att_count", q0.size(), 2);
      if (q0.size() >= 2) begin
         chk("att9_0", q0[0], 63);  chk("att9_1", q0[1], -64);
         chk("att15_0", q1[0], 0);  chk("att15_1", q1[1], -1);
      end

      // Sawtooth through a full wrap, silence alongside.
      do_reset();
      set_ch(0, 24'h010000, 0, 0);
      set_ch(1, 24'h123456, 3, 0);
      for (int i = 0; i < 858; i++) step();
      chk("saw_count", q0.size(), 256);
      if (q0.size() >= 256) begin
         chk("saw_first", q0[0], -32512);
         chk("saw_255", q0[254], 32512);
         chk("saw_wrap", q0[255], -32768);
         chk("silence", q1[100], 0);
      end

      // Random controls for 1000 cycles; tick count must be exact.
      do_reset();
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (tone_if.audio_tick === 1'b1) cnt++;
         randomize_inputs(15);
      end
      chk("tick_count_1000", cnt, 300);

      // One-cycle reset mid-stream, then first tick spacing.
      for (int i = 0; i < int'($urandom_range(5, 40)); i++) begin
         step();
         randomize_inputs(30);
      end
      do_reset();
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         step();
         if (tone_if.audio_tick === 1'b1) k = i;
      end
      chk("first_tick_edge", k, 4);

      // Reset landing while the tick is high must suppress its stage-1 work.
      k = 0;
      for (int i = 0; i < 20 && k == 0; i++) begin
         step();
         randomize_inputs(30);
         if (tick_m) k = 1;
      end
      chk("found_tick", k, 1);
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step();
         randomize_inputs(10);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
